muldiv_unit: RTL and testbench



---
 rtl/muldiv_unit.sv | 139 +++++++++++++
 tb/tb_muldiv_unit.sv | 191 +++++++++++++++++++
 2 files changed

// File: rtl/muldiv_unit.sv
// Iterative radix-2 multiply/divide unit for the RV32M ops.
// One operation in flight; fixed latency of WIDTH+2 cycles after the start cycle.
// Optional build macro MULDIV_EARLY_OUT_EN: zero-operand multiplies and divide-by-zero
// skip the iteration phase and finish in two cycles.
module muldiv_unit #(
  parameter int unsigned WIDTH = 32
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic [2:0]       op,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] result
);

  localparam int unsigned CntW = $clog2(WIDTH);

  typedef enum logic [1:0] {StIdle, StCalc, StFix, StDone} state_e;

  state_e               state_q, state_d;
  logic [CntW-1:0]      cnt_q;
  logic [2:0]           op_q;
  logic [WIDTH-1:0]     a_q;       // raw dividend, returned by REM on divide-by-zero
  logic [WIDTH-1:0]     opnd_q;    // multiplicand or divisor magnitude
  logic                 neg_q;     // negate the selected result in FIX
  logic [2*WIDTH-1:0]   acc_q;     // {hi, lo}: product, or {remainder, quotient}
  logic [WIDTH-1:0]     result_q;

  logic                 accept;
  logic                 sa, sb, neg_in, shortcut;
  logic [WIDTH-1:0]     a_mag, b_mag;
  logic [WIDTH:0]       mul_sum, div_trial;
  logic [2*WIDTH-1:0]   calc_next, prod;
  logic [WIDTH-1:0]     quot, rem, fix_res;

  assign accept = start && ((state_q == StIdle) || (state_q == StDone));

  // Operand sign handling and entry decisions for a newly accepted op
  always_comb begin
    sa     = a[WIDTH-1] & ((op == 3'b001) || (op == 3'b010) || (op == 3'b100) || (op == 3'b110));
    sb     = b[WIDTH-1] & ((op == 3'b001) || (op == 3'b100) || (op == 3'b110));
    a_mag  = sa ? -a : a;
    b_mag  = sb ? -b : b;
    neg_in = 1'b0;
    case (op)
      3'b001, 3'b100: neg_in = sa ^ sb;
      3'b010, 3'b110: neg_in = sa;
      default:        neg_in = 1'b0;
    endcase
`ifdef MULDIV_EARLY_OUT_EN
    shortcut = op[2] ? (b == '0) : ((a == '0) || (b == '0));
`else
    shortcut = 1'b0;
`endif
  end

  // Next-state logic
  always_comb begin
    state_d = state_q;
    case (state_q)
      StIdle: if (start) state_d = shortcut ? StFix : StCalc;
      StCalc: if (cnt_q == CntW'(WIDTH - 1)) state_d = StFix;
      StFix:  state_d = StDone;
      StDone: begin
        if (start) state_d = shortcut ? StFix : StCalc;
        else       state_d = StIdle;
      end
      default: state_d = StIdle;
    endcase
  end

  // One iteration: shift-add for multiply, restoring shift-subtract for divide
  always_comb begin
    mul_sum   = {1'b0, acc_q[2*WIDTH-1:WIDTH]} + {1'b0, opnd_q};
    div_trial = acc_q[2*WIDTH-1:WIDTH-1] - {1'b0, opnd_q};
    if (op_q[2]) begin
      calc_next = div_trial[WIDTH] ? {acc_q[2*WIDTH-2:0], 1'b0}
                                   : {div_trial[WIDTH-1:0], acc_q[WIDTH-2:0], 1'b1};
    end else begin
      calc_next = acc_q[0] ? {mul_sum, acc_q[WIDTH-1:1]} : {1'b0, acc_q[2*WIDTH-1:1]};
    end
  end

  // Sign restoration and result selection, including RISC-V divide-by-zero values
  always_comb begin
    prod    = neg_q ? -acc_q : acc_q;
    quot    = acc_q[WIDTH-1:0];
    rem     = acc_q[2*WIDTH-1:WIDTH];
    fix_res = '0;
    case (op_q)
      3'b000:                 fix_res = prod[WIDTH-1:0];
      3'b001, 3'b010, 3'b011: fix_res = prod[2*WIDTH-1:WIDTH];
      3'b100, 3'b101:         fix_res = (opnd_q == '0) ? '1 : (neg_q ? -quot : quot);
      3'b110, 3'b111:         fix_res = (opnd_q == '0) ? a_q : (neg_q ? -rem : rem);
      default:                fix_res = '0;
    endcase
  end

  // State register
  always_ff @(posedge clk or posedge reset) begin
    if (reset) state_q <= StIdle;
    else       state_q <= state_d;
  end

  // Datapath registers: latch on accept, iterate in CALC, capture result in FIX
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      cnt_q    <= '0;
      op_q     <= '0;
      a_q      <= '0;
      opnd_q   <= '0;
      neg_q    <= 1'b0;
      acc_q    <= '0;
      result_q <= '0;
    end else if (accept) begin
      cnt_q  <= '0;
      op_q   <= op;
      a_q    <= a;
      opnd_q <= op[2] ? b_mag : a_mag;
      neg_q  <= neg_in;
      if (op[2])         acc_q <= {{WIDTH{1'b0}}, a_mag};
      else if (shortcut) acc_q <= '0;  // zero product without iterating
      else               acc_q <= {{WIDTH{1'b0}}, b_mag};
    end else if (state_q == StCalc) begin
      acc_q <= calc_next;
      cnt_q <= cnt_q + CntW'(1);
    end else if (state_q == StFix) begin
      result_q <= fix_res;
    end
  end

  assign busy   = (state_q == StCalc) || (state_q == StFix);
  assign done   = (state_q == StDone);
  assign result = result_q;

endmodule

// File: tb/tb_muldiv_unit.sv
// Self-checking bench for muldiv_unit: directed RV32M cases, start-while-busy,
// back-to-back issue, mid-operation reset and randomized ops against a reference model.
module tb_muldiv_unit;

  logic        clk = 1'b0;
  logic        rst;
  logic        start;
  logic [2:0]  op;
  logic [31:0] a, b;
  logic        busy, done;
  logic [31:0] result;

  int n_checks = 0;
  int n_errors = 0;

  muldiv_unit #(.WIDTH(32)) dut (
    .clk    (clk),
    .reset  (rst),
    .start  (start),
    .op     (op),
    .a      (a),
    .b      (b),
    .busy   (busy),
    .done   (done),
    .result (result)
  );

  always #5 clk = ~clk;

  // Counted comparison; reports mismatches
  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  // RV32M semantics computed with plain 64-bit / integer arithmetic
  function automatic logic [31:0] ref_model(input logic [2:0] o, input logic [31:0] x,
                                            input logic [31:0] y);
    logic [63:0] sx, sy, ux, uy, p;
    int ix, iy;
    sx = {{32{x[31]}}, x};
    sy = {{32{y[31]}}, y};
    ux = {32'b0, x};
    uy = {32'b0, y};
    ix = x;
    iy = y;
    p  = '0;
    case (o)
      3'd0: begin p = sx * sy; return p[31:0];  end
      3'd1: begin p = sx * sy; return p[63:32]; end
      3'd2: begin p = sx * uy; return p[63:32]; end
      3'd3: begin p = ux * uy; return p[63:32]; end
      3'd4: begin
        if (y == 0) return 32'hFFFF_FFFF;
        if (x == 32'h8000_0000 && y == 32'hFFFF_FFFF) return 32'h8000_0000;
        return 32'(ix / iy);
      end
      3'd5: return (y == 0) ? 32'hFFFF_FFFF : x / y;
      3'd6: begin
        if (y == 0) return x;
        if (x == 32'h8000_0000 && y == 32'hFFFF_FFFF) return 32'h0;
        return 32'(ix % iy);
      end
      default: return (y == 0) ? x : x % y;
    endcase
  endfunction

  function automatic int exp_latency(input logic [2:0] o, input logic [31:0] x,
                                     input logic [31:0] y);
`ifdef MULDIV_EARLY_OUT_EN
    if (o[2] ? (y == 0) : (x == 0 || y == 0)) return 2;
`endif
    return 34;
  endfunction

  // Issue one op from a negedge, scramble inputs while it runs, return at the DONE negedge
  task automatic run_op(input string tag, input logic [2:0] o, input logic [31:0] x,
                        input logic [31:0] y, input logic [31:0] exp, input int glitch);
    int          lat, done_cyc;
    logic        bad_busy;
    logic [31:0] res;
    lat      = exp_latency(o, x, y);
    op       = o;
    a        = x;
    b        = y;
    start    = 1'b1;
    @(negedge clk);
    start    = 1'b0;
    done_cyc = -1;
    bad_busy = 1'b0;
    res      = '0;
    for (int cyc = 1; cyc <= 40 && done_cyc < 0; cyc++) begin
      op    = 3'($urandom);
      a     = $urandom;
      b     = $urandom;
      start = (cyc == glitch);
      if (busy !== (cyc < lat)) bad_busy = 1'b1;
      if (done === 1'b1) begin
        done_cyc = cyc;
        res      = result;
        if (busy !== 1'b0) bad_busy = 1'b1;
      end
      if (done_cyc < 0) @(negedge clk);
    end
    start = 1'b0;
    check_eq({tag, " busy"}, 32'(bad_busy), 32'd0);
    check_eq({tag, " done_cycle"}, 32'(done_cyc), 32'(lat));
    check_eq({tag, " result"}, res, exp);
  endtask

  initial begin
    logic [2:0]  o;
    logic [31:0] x, y;
    logic        saw_done;

    rst   = 1'b1;
    start = 1'b0;
    op    = '0;
    a     = '0;
    b     = '0;
    repeat (3) @(negedge clk);
    check_eq("reset busy", 32'(busy), 32'd0);
    check_eq("reset done", 32'(done), 32'd0);
    check_eq("reset result", result, 32'd0);
    rst = 1'b0;
    @(negedge clk);

    // Start pulse at cycle 10 is ignored; next op issued in the DONE cycle
    run_op("mul", 3'd0, 32'd7, 32'hFFFF_FFFD, 32'hFFFF_FFEB, 10);
    run_op("mulh_b2b", 3'd1, 32'h8000_0000, 32'h8000_0000, 32'h4000_0000, 0);
    run_op("mulhu", 3'd3, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFE, 0);
    run_op("mulhsu", 3'd2, 32'hFFFF_FFFF, 32'd2, 32'hFFFF_FFFF, 0);
    run_op("div", 3'd4, 32'hFFFF_FFF9, 32'd2, 32'hFFFF_FFFD, 0);
    run_op("rem", 3'd6, 32'hFFFF_FFF9, 32'd2, 32'hFFFF_FFFF, 0);
    run_op("divu", 3'd5, 32'd100, 32'd7, 32'd14, 0);
    run_op("remu", 3'd7, 32'd100, 32'd7, 32'd2, 0);
    run_op("divu0", 3'd5, 32'h1234_5678, 32'd0, 32'hFFFF_FFFF, 0);
    run_op("remu0", 3'd7, 32'h1234_5678, 32'd0, 32'h1234_5678, 0);
    run_op("div0", 3'd4, 32'hFFFF_FFF9, 32'd0, 32'hFFFF_FFFF, 0);
    run_op("rem0", 3'd6, 32'hFFFF_FFF9, 32'd0, 32'hFFFF_FFF9, 0);
    run_op("div_ovf", 3'd4, 32'h8000_0000, 32'hFFFF_FFFF, 32'h8000_0000, 0);
    run_op("rem_ovf", 3'd6, 32'h8000_0000, 32'hFFFF_FFFF, 32'h0, 0);
    run_op("mul_zero", 3'd0, 32'd0, 32'hDEAD_BEEF, 32'h0, 0);

    // Reset in cycle 15 of a DIV aborts it with no done pulse
    op    = 3'd4;
    a     = 32'h7654_3210;
    b     = 32'd13;
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    repeat (14) @(negedge clk);
    rst = 1'b1;
    #1;
    check_eq("abort busy", 32'(busy), 32'd0);
    check_eq("abort done", 32'(done), 32'd0);
    check_eq("abort result", result, 32'd0);
    @(negedge clk);
    rst      = 1'b0;
    saw_done = 1'b0;
    repeat (40) begin
      @(negedge clk);
      if (done !== 1'b0 || busy !== 1'b0) saw_done = 1'b1;
    end
    check_eq("abort quiet", 32'(saw_done), 32'd0);
    run_op("after_reset", 3'd5, 32'h7654_3210, 32'd13, 32'h7654_3210 / 32'd13, 0);

    // Randomized ops, with zero and overflow operands mixed in, random idle gaps
    for (int i = 0; i < 40; i++) begin
      o = 3'($urandom);
      x = $urandom;
      y = $urandom;
      case ($urandom_range(0, 9))
        0: y = '0;
        1: x = '0;
        2: begin x = 32'h8000_0000; y = 32'hFFFF_FFFF; end
        3: y = 32'($urandom_range(1, 15));
        default: ;
      endcase
      run_op("rand", o, x, y, ref_model(o, x, y), 0);
      repeat ($urandom_range(0, 2)) @(negedge clk);
    end

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
